ps2_receiver: RTL and testbench

- Deserialises the raw PS/2 keyboard clock/data lines into scan-code bytes, one per frame.
- Delivers each byte with a single-cycle strobe to the ZX key-matrix block downstream on the CLOCK_50 domain.
- Synchronises and glitch-filters the slow PS/2 clock and checks frame framing and odd parity.
- Recovers from stalled or truncated frames with a watchdog.

---
 rtl/ps2_receiver_if.sv | 28 ++
 rtl/ps2_receiver.sv | 149 ++++++++++++++
 tb/tb_ps2_receiver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bus: raw keyboard lines in, decoded scan-code byte and strobes out.
// The receiver drives the outputs through the master modport; a consumer uses slave.
interface ps2_receiver_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_data;
    logic       ps2_data_clk;
    logic       ps2_err;
    logic       busy;

    modport master (
        input  ps2_clk,
        input  ps2_dat,
        output ps2_data,
        output ps2_data_clk,
        output ps2_err,
        output busy
    );

    modport slave (
        output ps2_clk,
        output ps2_dat,
        input  ps2_data,
        input  ps2_data_clk,
        input  ps2_err,
        input  busy
    );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 clock, deserialises 11-bit
// frames, checks start/odd-parity/stop and emits one strobe per byte on CLOCK_50.
module ps2_receiver #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input logic            CLOCK_50,
    input logic            reset,
    ps2_receiver_if.master bus
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       s_clk;
    logic       s_dat;

    logic       fc_q;
    logic [7:0] flt_cnt_q;
    logic       fall_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0] data_q, data_d;
    logic       data_clk_q, data_clk_d;
    logic       err_q, err_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_dat};
        end
    end

    assign s_clk = clk_sync_q[1];
    assign s_dat = dat_sync_q[1];

    // fall_q rises in the same cycle fc_q drops, so it marks the filtered falling edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fc_q      <= 1'b1;
            flt_cnt_q <= 8'd0;
            fall_q    <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (s_clk == fc_q) begin
                flt_cnt_q <= 8'd0;
            end else if (flt_cnt_q == 8'(FILTER_LEN - 1)) begin
                fc_q      <= s_clk;
                flt_cnt_q <= 8'd0;
                fall_q    <= ~s_clk;
            end else begin
                flt_cnt_q <= flt_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            wd_q       <= '0;
            data_q     <= 8'h00;
            data_clk_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wd_q       <= wd_d;
            data_q     <= data_d;
            data_clk_q <= data_clk_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        wd_d       = wd_q;
        data_d     = data_q;
        data_clk_d = 1'b0;
        err_d      = 1'b0;

        if (state_q != IDLE && !fall_q) begin
            // A stalled frame is dropped silently; an edge in the timeout cycle takes priority.
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                wd_d    = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        if (fall_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!s_dat) begin
                        state_d   = SHIFT;
                        bit_cnt_d = 3'd0;
                        wd_d      = '0;
                    end
                end
                SHIFT: begin
                    shift_d   = {s_dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    wd_d      = '0;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = s_dat;
                    wd_d    = '0;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    wd_d    = '0;
                    if (s_dat && (^{shift_q, par_q})) begin
                        data_d     = shift_q;
                        data_clk_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.ps2_data     = data_q;
    assign bus.ps2_data_clk = data_clk_q;
    assign bus.ps2_err      = err_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomised frame stimulus with a queue-based scoreboard; a negedge monitor pops the
// expected byte/error whenever the receiver strobes.
module tb_ps2_receiver;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 1000;
    localparam int          H          = 30;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   tests    = 0;
    int   fails    = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [7:0] held = 8'h00;

    ps2_receiver_if bus ();

    ps2_receiver #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Scoreboard monitor: every strobe must match the head of the expectation queue.
    always @(negedge CLOCK_50) begin
        if (reset) begin
            held = 8'h00;
        end else if (bus.ps2_data_clk || bus.ps2_err) begin
            check("strobe_exclusive", {31'd0, bus.ps2_data_clk & bus.ps2_err}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: data_clk=%0b err=%0b data=%0h, expected none",
                         bus.ps2_data_clk, bus.ps2_err, bus.ps2_data);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {31'd0, bus.ps2_err}, {31'd0, e.err});
                if (e.err) begin
                    check("data_held_on_err", {24'd0, bus.ps2_data}, {24'd0, held});
                end else begin
                    check("data_value", {24'd0, bus.ps2_data}, {24'd0, e.data});
                    held = e.data;
                end
            end
        end
    end

    // Sends the first nbits of a frame; glitches are short low pulses in the high phase.
    task automatic send(input logic [7:0] d, input bit bad_par, input bit stop,
                        input int nbits, input int nglitch);
        logic [10:0] f;
        exp_t x;
        f = {stop, (~^d) ^ bad_par, d, 1'b0};
        if (nbits == 11) begin
            x.err  = bad_par || !stop;
            x.data = d;
            exp_q.push_back(x);
        end
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_dat = f[i];
            if (i < nglitch) begin
                wait_cyc(10);
                bus.ps2_clk = 1'b0;
                wait_cyc(4);
                bus.ps2_clk = 1'b1;
                wait_cyc(H - 14);
            end else begin
                wait_cyc(H);
            end
            bus.ps2_clk = 1'b0;
            wait_cyc(H);
            if (i == 5) check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
        if (nbits == 11) check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_data", {24'd0, bus.ps2_data}, 32'd0);
        check("rst_data_clk", {31'd0, bus.ps2_data_clk}, 32'd0);
        check("rst_err", {31'd0, bus.ps2_err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         r;
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        wait_cyc(3);
        check_reset_outputs();
        reset = 1'b0;
        wait_cyc(20);

        // Bad parity straight after reset: error strobe, data stays 00.
        send(8'h1C, 1'b1, 1'b1, 11, 0);
        wait_cyc(40);
        check("data_after_err", {24'd0, bus.ps2_data}, 32'h00);
        send(8'h1C, 1'b0, 1'b1, 11, 0);
        wait_cyc(40);

        // Back-to-back frames.
        send(8'hF0, 1'b0, 1'b1, 11, 0);
        send(8'h1C, 1'b0, 1'b1, 11, 0);
        wait_cyc(40);

        // Sub-filter glitches on the first five bits.
        send(8'h29, 1'b0, 1'b1, 11, 5);
        wait_cyc(40);

        // Truncated frame: watchdog must drop it silently.
        send(8'hA5, 1'b0, 1'b1, 5, 0);
        wait_cyc(TIMEOUT - 50);
        check("busy_before_timeout", {31'd0, bus.busy}, 32'd1);
        wait_cyc(60);
        check("busy_after_timeout", {31'd0, bus.busy}, 32'd0);
        send(8'h5A, 1'b0, 1'b1, 11, 0);
        wait_cyc(40);
        check("data_after_timeout", {24'd0, bus.ps2_data}, 32'h5A);

        // False start: data high on the first edge.
        bus.ps2_dat = 1'b1;
        wait_cyc(H);
        bus.ps2_clk = 1'b0;
        wait_cyc(H);
        check("busy_false_start", {31'd0, bus.busy}, 32'd0);
        bus.ps2_clk = 1'b1;
        wait_cyc(H);

        // Reset in the middle of a frame, then a clean frame.
        send(8'h77, 1'b0, 1'b1, 7, 0);
        check("busy_before_reset", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        wait_cyc(3);
        check_reset_outputs();
        reset = 1'b0;
        wait_cyc(20);
        send(8'h12, 1'b0, 1'b1, 11, 0);
        wait_cyc(40);
        check("data_after_reset", {24'd0, bus.ps2_data}, 32'h12);

        // Random frames with occasional parity and stop errors.
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom);
            r = $urandom_range(0, 9);
            send(d, r == 0, r != 1, 11, 0);
            wait_cyc($urandom_range(0, 40));
        end

        wait_cyc(50);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
